// File: rtl/timer_pkg.sv
// Shared types, seven-segment patterns and BCD helpers for the game timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int MAX_DIGITS = 6;

    function automatic int digit_radix(input int k, input int mmss);
        return (mmss != 0 && k == 1) ? 6 : 10;
    endfunction

    // Largest count the display can hold: product of all digit radices minus one.
    function automatic int max_count(input int digits, input int mmss);
        int prod;
        prod = 1;
        for (int k = 0; k < digits; k++) begin
            prod = prod * digit_radix(k, mmss);
        end
        return prod - 1;
    endfunction

    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value, input int digits,
                                                       input int mmss);
        logic [4*MAX_DIGITS-1:0] result;
        int rest;
        int d;
        result = '0;
        rest   = value;
        for (int k = 0; k < digits; k++) begin
            d                = rest % digit_radix(k, mmss);
            rest             = rest / digit_radix(k, mmss);
            result[k*4 +: 4] = d[3:0];
        end
        return result;
    endfunction

    // True when every digit below k sits at its wrap point, i.e. digit k must step too.
    function automatic logic lower_wrap(input logic [4*MAX_DIGITS-1:0] value, input int k,
                                        input int mmss, input logic dn);
        logic       all_wrap;
        logic [3:0] nib;
        int         top;
        all_wrap = 1'b1;
        for (int j = 0; j < k; j++) begin
            nib = value[j*4 +: 4];
            top = digit_radix(j, mmss) - 1;
            if (dn) begin
                if (nib != 4'd0) all_wrap = 1'b0;
            end else begin
                if (int'(nib) < top) all_wrap = 1'b0;
            end
        end
        return all_wrap;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD nibble to an active-low seven-segment pattern; non-decimal nibbles blank.
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_game_timer.sv
// Up/down BCD game timer with prescaler, pause, terminal detect and per-digit seven-segment decode.
// Handshake-free control: start is a one-cycle pulse, pause is a level, outputs are registered strobes/levels.
module bcd_game_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int DIGITS    = 3,
    parameter int MMSS      = 1,
    parameter int LIMIT_SEC = 60
) (
    input  logic                  Clck,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  down,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  running,
    output logic                  done,
    output logic                  done_pulse,
    output logic                  tick,
    output state_t                state
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] LIMIT_BCD  = BW'(to_bcd(LIMIT_SEC, DIGITS, MMSS));

    if (TICK_DIV < 2) begin : g_bad_div
        $error("bcd_game_timer: TICK_DIV must be 2 or more");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_game_timer: DIGITS must be 1..6");
    end
    if (LIMIT_SEC <= 0 || LIMIT_SEC > max_count(DIGITS, MMSS)) begin : g_bad_limit
        $error("bcd_game_timer: LIMIT_SEC is 0 or does not fit in DIGITS digits");
    end

    state_t          state_q;
    state_t          state_next;
    logic [PW-1:0]   presc;
    logic            down_q;
    logic [BW-1:0]   bcd_next;
    logic [BW-1:0]   load_value;
    logic [BW-1:0]   term_value;
    logic            tick_due;
    logic            terminal;

    assign tick_due   = (state_q == ST_RUN) && (presc == PRESC_LAST);
    assign load_value = down ? LIMIT_BCD : '0;
    assign term_value = down_q ? '0 : LIMIT_BCD;
    assign terminal   = tick_due && (bcd_next == term_value);

    // Each digit steps only when all lower digits are at their wrap point.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        localparam logic [3:0] TOP = (MMSS != 0 && k == 1) ? 4'd5 : 4'd9;
        logic [3:0] value;
        logic [3:0] stepped;
        logic       cin;

        assign cin = lower_wrap((4*MAX_DIGITS)'(bcd), k, MMSS, down_q);

        always_comb begin
            stepped = value;
            if (cin) begin
                if (!down_q) begin
                    stepped = (value >= TOP) ? 4'd0 : value + 4'd1;
                end else begin
                    stepped = (value == 4'd0 || value > TOP) ? TOP : value - 4'd1;
                end
            end
        end

        always_ff @(posedge Clck) begin
            if (!reset) begin
                value <= 4'd0;
            end else if (start) begin
                value <= load_value[4*k +: 4];
            end else if (tick_due) begin
                value <= stepped;
            end
        end

        assign bcd[4*k +: 4]      = value;
        assign bcd_next[4*k +: 4] = stepped;

        seg7_decode u_seg (
            .nibble (value),
            .seg    (seg[7*k +: 7])
        );
    end

    always_ff @(posedge Clck) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (terminal)   state_next = ST_DONE;
                    else if (pause) state_next = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (!pause) state_next = ST_RUN;
                end
                default: state_next = state_q;
            endcase
        end
    end

    always_comb begin
        running = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        state   = state_q;
    end

    // Prescaler advances whenever the FSM is in RUN; a pause only takes hold from PAUSED onward.
    always_ff @(posedge Clck) begin
        if (!reset) begin
            presc      <= '0;
            down_q     <= 1'b0;
            tick       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            tick       <= 1'b0;
            done_pulse <= 1'b0;
            if (start) begin
                presc  <= '0;
                down_q <= down;
            end else if (state_q == ST_RUN) begin
                if (presc == PRESC_LAST) begin
                    presc      <= '0;
                    tick       <= 1'b1;
                    done_pulse <= terminal;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_game_timer.sv
// Directed bench: mm:ss up/down timers, a plain decimal timer and the stand-alone digit decoder.
module tb_bcd_game_timer;
    import timer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, pause, down, start_a, start_b, start_c;

    logic [11:0] bcd_a, bcd_b;
    logic [7:0]  bcd_c;
    logic [20:0] seg_a, seg_b;
    logic [13:0] seg_c;
    logic        running_a, done_a, done_pulse_a, tick_a;
    logic        running_b, done_b, done_pulse_b, tick_b;
    logic        running_c, done_c, done_pulse_c, tick_c;
    state_t      st_a, st_b, st_c;
    logic [3:0]  nib;
    logic [6:0]  nib_seg;

    int total = 0;
    int bad   = 0;

    bcd_game_timer #(.TICK_DIV(4), .DIGITS(3), .MMSS(1), .LIMIT_SEC(75)) dut_a (
        .Clck(clk), .reset(reset), .start(start_a), .pause(pause), .down(down),
        .bcd(bcd_a), .seg(seg_a), .running(running_a), .done(done_a),
        .done_pulse(done_pulse_a), .tick(tick_a), .state(st_a));

    bcd_game_timer #(.TICK_DIV(4), .DIGITS(3), .MMSS(1), .LIMIT_SEC(60)) dut_b (
        .Clck(clk), .reset(reset), .start(start_b), .pause(pause), .down(down),
        .bcd(bcd_b), .seg(seg_b), .running(running_b), .done(done_b),
        .done_pulse(done_pulse_b), .tick(tick_b), .state(st_b));

    bcd_game_timer #(.TICK_DIV(4), .DIGITS(2), .MMSS(0), .LIMIT_SEC(99)) dut_c (
        .Clck(clk), .reset(reset), .start(start_c), .pause(pause), .down(down),
        .bcd(bcd_c), .seg(seg_c), .running(running_c), .done(done_c),
        .done_pulse(done_pulse_c), .tick(tick_c), .state(st_c));

    seg7_decode u_dec (.nibble(nib), .seg(nib_seg));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] dec_exp [16];

    initial begin
        dec_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        reset = 1'b0; pause = 1'b0; down = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; nib = 4'd0;

        // decoder table including non-decimal nibbles
        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            #1;
            check_eq($sformatf("dec_%0d", i), 32'(nib_seg), 32'(dec_exp[i]));
        end

        step(3);
        check_eq("rst_bcd", 32'(bcd_a), 32'h000);
        check_eq("rst_run", 32'(running_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_tick", 32'(tick_a), 32'd0);
        check_eq("rst_dp", 32'(done_pulse_a), 32'd0);
        check_eq("rst_state", 32'(st_a), 32'(ST_IDLE));
        check_eq("rst_seg", 32'(seg_a), 32'({3{7'b1000000}}));
        reset = 1'b1;
        step(1);

        // up count to 75 s
        down = 1'b0; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check_eq("up_start_run", 32'(running_a), 32'd1);
        check_eq("up_start_bcd", 32'(bcd_a), 32'h000);
        check_eq("up_start_tick", 32'(tick_a), 32'd0);
        step(4);
        check_eq("up_t1_tick", 32'(tick_a), 32'd1);
        check_eq("up_t1_bcd", 32'(bcd_a), 32'h001);
        step(4 * 58);
        check_eq("up_059_bcd", 32'(bcd_a), 32'h059);
        step(3);
        check_eq("up_gap_tick", 32'(tick_a), 32'd0);
        step(1);
        check_eq("up_100_bcd", 32'(bcd_a), 32'h100);
        check_eq("up_100_tick", 32'(tick_a), 32'd1);
        step(4 * 15);
        check_eq("up_end_bcd", 32'(bcd_a), 32'h115);
        check_eq("up_end_dp", 32'(done_pulse_a), 32'd1);
        check_eq("up_end_run", 32'(running_a), 32'd0);
        check_eq("up_end_done", 32'(done_a), 32'd1);
        step(1);
        check_eq("up_dp_fall", 32'(done_pulse_a), 32'd0);
        step(8);
        check_eq("up_frozen_bcd", 32'(bcd_a), 32'h115);
        check_eq("up_frozen_tick", 32'(tick_a), 32'd0);
        check_eq("up_frozen_done", 32'(done_a), 32'd1);

        // restart from DONE, then restart mid-run at 0x042
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check_eq("rs_done_fall", 32'(done_a), 32'd0);
        check_eq("rs_run", 32'(running_a), 32'd1);
        check_eq("rs_bcd", 32'(bcd_a), 32'h000);
        step(4 * 42);
        check_eq("rs_042", 32'(bcd_a), 32'h042);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check_eq("rs2_bcd", 32'(bcd_a), 32'h000);
        check_eq("rs2_tick", 32'(tick_a), 32'd0);
        step(3);
        check_eq("rs2_presc_tick", 32'(tick_a), 32'd0);
        step(1);
        check_eq("rs2_first_tick", 32'(tick_a), 32'd1);
        check_eq("rs2_first_bcd", 32'(bcd_a), 32'h001);

        // pause for 10 cycles right after a tick
        pause = 1'b1;
        step(1);
        check_eq("ps_state", 32'(st_a), 32'(ST_PAUSED));
        check_eq("ps_run", 32'(running_a), 32'd0);
        step(9);
        check_eq("ps_hold_bcd", 32'(bcd_a), 32'h001);
        check_eq("ps_hold_tick", 32'(tick_a), 32'd0);
        pause = 1'b0;
        step(3);
        check_eq("ps_resume_run", 32'(running_a), 32'd1);
        check_eq("ps_resume_tick0", 32'(tick_a), 32'd0);
        step(1);
        check_eq("ps_resume_tick", 32'(tick_a), 32'd1);
        check_eq("ps_resume_bcd", 32'(bcd_a), 32'h002);

        // reset with a tick due on the next edge, then start held during reset
        step(3);
        check_eq("rr_pre_bcd", 32'(bcd_a), 32'h002);
        reset = 1'b0;
        step(1);
        check_eq("rr_tick", 32'(tick_a), 32'd0);
        check_eq("rr_bcd", 32'(bcd_a), 32'h000);
        check_eq("rr_run", 32'(running_a), 32'd0);
        check_eq("rr_state", 32'(st_a), 32'(ST_IDLE));
        start_a = 1'b1;
        step(1);
        check_eq("rr_start_ign", 32'(st_a), 32'(ST_IDLE));
        reset = 1'b1; start_a = 1'b0;
        step(2);
        check_eq("rr_still_idle", 32'(running_a), 32'd0);

        // down count from 60 s, pause coincident with the terminal tick
        down = 1'b1; start_b = 1'b1;
        step(1);
        start_b = 1'b0; down = 1'b0;
        check_eq("dn_load", 32'(bcd_b), 32'h100);
        check_eq("dn_run", 32'(running_b), 32'd1);
        step(4);
        check_eq("dn_059", 32'(bcd_b), 32'h059);
        check_eq("dn_059_tick", 32'(tick_b), 32'd1);
        step(4 * 58);
        check_eq("dn_001", 32'(bcd_b), 32'h001);
        step(3);
        pause = 1'b1;
        step(1);
        check_eq("dn_end_bcd", 32'(bcd_b), 32'h000);
        check_eq("dn_end_dp", 32'(done_pulse_b), 32'd1);
        check_eq("dn_end_done", 32'(done_b), 32'd1);
        check_eq("dn_end_state", 32'(st_b), 32'(ST_DONE));
        check_eq("dn_end_seg", 32'(seg_b), 32'({3{7'b1000000}}));
        step(1);
        check_eq("dn_pause_ign", 32'(st_b), 32'(ST_DONE));
        check_eq("dn_dp_fall", 32'(done_pulse_b), 32'd0);
        pause = 1'b0;

        // plain decimal 2-digit timer
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        step(36);
        check_eq("dec_09", 32'(bcd_c), 32'h09);
        step(4);
        check_eq("dec_10", 32'(bcd_c), 32'h10);
        check_eq("dec_10_seg", 32'(seg_c), 32'({7'b1111001, 7'b1000000}));
        step(4 * 89);
        check_eq("dec_99", 32'(bcd_c), 32'h99);
        check_eq("dec_99_dp", 32'(done_pulse_c), 32'd1);
        check_eq("dec_99_seg", 32'(seg_c), 32'({2{7'b0010000}}));
        step(4);
        check_eq("dec_99_hold", 32'(bcd_c), 32'h99);
        check_eq("dec_99_done", 32'(done_c), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
